// File: rtl/intc_pkg.sv
// Shared types and default sizing for the interrupt acceptance controller.
package intc_pkg;

   localparam int LINE_WIDTH_FULL_DEF = 5;
   localparam int TIMEOUT_CYC_DEF     = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } intc_state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder: index 0 is the highest priority line.
module intc_prio_enc #(
   parameter int WIDTH = 5,
   parameter int IDX_W = 3
) (
   input  logic [WIDTH-1:0] req,
   output logic             valid,
   output logic [IDX_W-1:0] index
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            index = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/intc_accept_ctrl.sv
// Sequential interrupt acceptance: pick the highest-priority pending line,
// present it to the CPU with req/ack, clear the source, hold until EOI.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing presented; accept a new request when enabled
// REQ     | cpu_irq high, waiting for ack; may retarget, cancel, time out
// SERVICE | line accepted and cleared; waiting for end-of-interrupt
module intc_accept_ctrl
   import intc_pkg::*;
#(
   parameter  int LINE_WIDTH_FULL = LINE_WIDTH_FULL_DEF,
   parameter  int TIMEOUT_CYC     = TIMEOUT_CYC_DEF,
   localparam int VEC_W           = (LINE_WIDTH_FULL > 1) ? $clog2(LINE_WIDTH_FULL) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [LINE_WIDTH_FULL-1:0] priority_selected,
   input  logic                       intc_en,
   input  logic                       cpu_ack,
   input  logic                       cpu_eoi,
   output logic                       cpu_irq,
   output logic [VEC_W-1:0]           irq_vector,
   output logic [LINE_WIDTH_FULL-1:0] irq_clr,
   output logic                       in_service,
   output logic                       irq_timeout
);

   localparam int                 TMO_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   intc_state_e                state;
   logic [TMO_W-1:0]           tmo_cnt;
   logic                       enc_valid;
   logic [VEC_W-1:0]           enc_index;
   logic [LINE_WIDTH_FULL-1:0] vec_onehot;
   logic                       cur_pending;

   intc_prio_enc #(
      .WIDTH (LINE_WIDTH_FULL),
      .IDX_W (VEC_W)
   ) u_prio_enc (
      .req   (priority_selected),
      .valid (enc_valid),
      .index (enc_index)
   );

   // One-hot of the presented line, used both for the clear pulse and to
   // check whether the presented request has been withdrawn.
   assign vec_onehot  = LINE_WIDTH_FULL'(1) << irq_vector;
   assign cur_pending = |(priority_selected & vec_onehot);

   // Acceptance FSM with timeout counter; every output is a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         tmo_cnt     <= '0;
         cpu_irq     <= 1'b0;
         irq_vector  <= '0;
         irq_clr     <= '0;
         in_service  <= 1'b0;
         irq_timeout <= 1'b0;
      end else begin
         irq_clr     <= '0;
         irq_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (intc_en && enc_valid) begin
                  irq_vector <= enc_index;
                  cpu_irq    <= 1'b1;
                  tmo_cnt    <= '0;
                  state      <= REQ;
               end
            end
            REQ: begin
               // Ack binds to the vector driven this cycle, so it beats
               // withdrawal and retargeting.
               if (cpu_ack) begin
                  cpu_irq    <= 1'b0;
                  in_service <= 1'b1;
                  irq_clr    <= vec_onehot;
                  state      <= SERVICE;
               end else if (!intc_en || !cur_pending) begin
                  cpu_irq <= 1'b0;
                  state   <= IDLE;
               end else if (enc_index < irq_vector) begin
                  irq_vector <= enc_index;
                  tmo_cnt    <= '0;
               end else if (tmo_cnt == TMO_LAST) begin
                  irq_timeout <= 1'b1;
                  cpu_irq     <= 1'b0;
                  state       <= IDLE;
               end else if (tmo_cnt != '1) begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            SERVICE: begin
               if (cpu_eoi) begin
                  in_service <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
